// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that rasterises client rectangles onto the vga_adapter pixel port.
// Optional PLOT_CLIP_EN suppresses plot for pixels outside SCREEN_W x SCREEN_H.
module vga_plot_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_x,
  input  logic [NUM_REQ*7-1:0]   req_y,
  input  logic [NUM_REQ*8-1:0]   req_w,
  input  logic [NUM_REQ*7-1:0]   req_h,
  input  logic [NUM_REQ*3-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || SCREEN_W > 256 || SCREEN_H > 128) begin : g_param_check
    $error("vga_plot_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour;
  } rect_t;

  state_t             state, state_nxt;
  rect_t              rect, rect_nxt;
  rect_t              cand [NUM_REQ];
  logic [IDX_W-1:0]   last, last_nxt, owner, owner_nxt, sel;
  logic               found, emit;
  logic [7:0]         cx, cx_nxt;
  logic [6:0]         cy, cy_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic               busy_nxt, plot_nxt;
  logic [7:0]         x_nxt;
  logic [6:0]         y_nxt;
  logic [2:0]         colour_nxt;
`ifdef PLOT_CLIP_EN
  logic [8:0]         px9;
  logic [7:0]         py8;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
    assign cand[i] = '{x: req_x[8*i +: 8], y: req_y[7*i +: 7], w: req_w[8*i +: 8],
                       h: req_h[7*i +: 7], colour: req_colour[3*i +: 3]};
  end

  // First requester searching upward from last+1, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[IDX_W'((32'(last) + k) % NUM_REQ)]) begin
        found = 1'b1;
        sel   = IDX_W'((32'(last) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rect_nxt   = rect;
    last_nxt   = last;
    owner_nxt  = owner;
    cx_nxt     = cx;
    cy_nxt     = cy;
    gnt_nxt    = '0;
    done_nxt   = '0;
    busy_nxt   = (state != IDLE);
    x_nxt      = x;
    y_nxt      = y;
    colour_nxt = colour;
    plot_nxt   = 1'b0;
    emit       = 1'b0;
`ifdef PLOT_CLIP_EN
    px9        = '0;
    py8        = '0;
`endif

    // cx/cy always name the pixel being presented on the outputs next cycle.
    unique case (state)
      IDLE: begin
        if (found) begin
          rect_nxt     = cand[sel];
          owner_nxt    = sel;
          gnt_nxt[sel] = 1'b1;
          busy_nxt     = 1'b1;
          cx_nxt       = '0;
          cy_nxt       = '0;
          if (rect_nxt.w == 8'd0 || rect_nxt.h == 7'd0) begin
            state_nxt = FINISH;
          end else begin
            emit      = 1'b1;
            state_nxt = (rect_nxt.w == 8'd1 && rect_nxt.h == 7'd1) ? FINISH : DRAW;
          end
        end
      end
      DRAW: begin
        emit = 1'b1;
        if (cx == rect.w - 8'd1) begin
          cx_nxt = '0;
          cy_nxt = cy + 7'd1;
        end else begin
          cx_nxt = cx + 8'd1;
        end
        if (cx_nxt == rect.w - 8'd1 && cy_nxt == rect.h - 7'd1) state_nxt = FINISH;
      end
      FINISH: begin
        done_nxt[owner] = 1'b1;
        last_nxt        = owner;
        cx_nxt          = '0;
        cy_nxt          = '0;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (emit) begin
`ifdef PLOT_CLIP_EN
      px9      = 9'(rect_nxt.x) + 9'(cx_nxt);
      py8      = 8'(rect_nxt.y) + 8'(cy_nxt);
      x_nxt    = px9[7:0];
      y_nxt    = py8[6:0];
      plot_nxt = (px9 < 9'(SCREEN_W)) && (py8 < 8'(SCREEN_H));
`else
      x_nxt    = rect_nxt.x + cx_nxt;
      y_nxt    = rect_nxt.y + cy_nxt;
      plot_nxt = 1'b1;
`endif
      colour_nxt = rect_nxt.colour;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      rect   <= '0;
      last   <= IDX_W'(NUM_REQ - 1);
      owner  <= '0;
      cx     <= '0;
      cy     <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rect   <= rect_nxt;
      last   <= last_nxt;
      owner  <= owner_nxt;
      cx     <= cx_nxt;
      cy     <= cy_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      colour <= colour_nxt;
      plot   <= plot_nxt;
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus queues expected grants, pixels and
// completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_vga_plot_arbiter;

  localparam int unsigned NUM_REQ = 4;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_x;
  logic [NUM_REQ*7-1:0] req_y;
  logic [NUM_REQ*8-1:0] req_w;
  logic [NUM_REQ*7-1:0] req_h;
  logic [NUM_REQ*3-1:0] req_colour;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [7:0]           x;
  logic [6:0]           y;
  logic [2:0]           colour;
  logic                 plot;

  vga_plot_arbiter #(.NUM_REQ(NUM_REQ), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .gnt(gnt), .done(done),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_pix [$];
  int          exp_gnt [$];
  int          exp_done[$];
  int gnt_cnt = 0, done_cnt = 0, gnt_cyc = 0, done_cyc = 0;
  int last_plot_cyc = 0, max_gap = 0;
  logic [17:0] exp_e;
  int          exp_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req_v);
    n_checks++;
    if (got == req_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req_v);
  endtask

  // Monitor: compares every plotted pixel, grant and completion against the queues.
  initial forever begin
    @(negedge clock);
    if (plot) begin
      if (exp_pix.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d, required no plot", x, y, colour);
      end else begin
        exp_e = exp_pix.pop_front();
        check("pixel", 32'({x, y, colour}), 32'(exp_e));
      end
      if (cyc - last_plot_cyc > max_gap) max_gap = cyc - last_plot_cyc;
      last_plot_cyc = cyc;
    end
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_gnt: got 0x%0h, required none", gnt);
      end else begin
        exp_i = exp_gnt.pop_front();
        check("gnt_onehot", 32'(gnt), 32'(1) << exp_i);
      end
      gnt_cnt++;
      gnt_cyc = cyc;
    end
    if (done != '0) begin
      if (exp_done.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got 0x%0h, required none", done);
      end else begin
        exp_i = exp_done.pop_front();
        check("done_onehot", 32'(done), 32'(1) << exp_i);
      end
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_client(input int i, input int xx, input int yy, input int ww,
                            input int hh, input int cc);
    req_x[8*i +: 8]      = 8'(xx);
    req_y[7*i +: 7]      = 7'(yy);
    req_w[8*i +: 8]      = 8'(ww);
    req_h[7*i +: 7]      = 7'(hh);
    req_colour[3*i +: 3] = 3'(cc);
  endtask

  task automatic push_pix(input int xx, input int yy, input int cc);
    exp_pix.push_back({8'(xx), 7'(yy), 3'(cc)});
  endtask

  // Raster-order expected pixels for an on-screen rectangle.
  task automatic push_rect(input int xx, input int yy, input int ww, input int hh, input int cc);
    for (int j = 0; j < hh; j++)
      for (int i = 0; i < ww; i++)
        push_pix(xx + i, yy + j, cc);
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 20000) begin
      tick();
      k++;
    end
    if (done_cnt < target) begin
      n_checks++;
      $display("FAIL %s timeout: got %0d dones, required %0d", name, done_cnt, target);
    end
  endtask

  int c0, base;

  initial begin
    resetn = 1'b0; req = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_plot", 32'(plot), 32'(0));
    check("rst_xyc", 32'({x, y, colour}), 32'(0));
    resetn = 1'b1;
    tick();

    // 1: single 16x8 rectangle touching the right screen edge
    set_client(0, 144, 50, 16, 8, 3);
    exp_gnt.push_back(0); push_rect(144, 50, 16, 8, 3); exp_done.push_back(0);
    base = done_cnt; c0 = cyc; req = 4'b0001;
    tick();
    req = '0;
    check("t1_gnt_latency", 32'(gnt_cyc - c0), 32'(1));
    check("t1_plot_with_gnt", 32'(plot), 32'(1));
    check("t1_busy", 32'(busy), 32'(1));
    wait_done(base + 1, "t1_done");
    check("t1_done_latency", 32'(done_cyc - c0), 32'(129));
    tick();
    check("t1_busy_after", 32'(busy), 32'(0));

    // restore reset priority (client 0 first) for the round-robin sweep
    resetn = 1'b0; tick(); resetn = 1'b1; tick();

    // 2: all four clients held high; order 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_client(i, 20 * i, 10 * i, 2, 2, i + 1);
    for (int n = 0; n < 5; n++) begin
      exp_gnt.push_back(n % 4);
      push_rect(20 * (n % 4), 10 * (n % 4), 2, 2, (n % 4) + 1);
      exp_done.push_back(n % 4);
    end
    base = done_cnt; c0 = cyc; last_plot_cyc = cyc; max_gap = 0; req = 4'b1111;
    wait_done(base + 5, "t2_done");
    req = '0;
    check("t2_last_done_cycle", 32'(done_cyc - c0), 32'(25));
    n_checks++;
    if (max_gap <= 2) n_pass++;
    else $display("FAIL t2_plot_gap: got %0d cycles, required at most 2", max_gap);
    tick();

    // 3: zero-width rectangle, no pixels
    set_client(2, 30, 30, 0, 5, 7);
    exp_gnt.push_back(2); exp_done.push_back(2);
    base = done_cnt; c0 = cyc; req = 4'b0100;
    tick();
    req = '0;
    check("t3_gnt_latency", 32'(gnt_cyc - c0), 32'(1));
    wait_done(base + 1, "t3_done");
    check("t3_done_latency", 32'(done_cyc - c0), 32'(2));
    check("t3_busy_at_done", 32'(busy), 32'(1));
    tick();

    // 4: rectangle straddling the bottom-right corner
    set_client(1, 158, 119, 4, 2, 5);
    exp_gnt.push_back(1); exp_done.push_back(1);
`ifdef PLOT_CLIP_EN
    push_pix(158, 119, 5); push_pix(159, 119, 5);
`else
    push_pix(158, 119, 5); push_pix(159, 119, 5); push_pix(160, 119, 5); push_pix(161, 119, 5);
    push_pix(158, 120, 5); push_pix(159, 120, 5); push_pix(160, 120, 5); push_pix(161, 120, 5);
`endif
    base = done_cnt; c0 = cyc; req = 4'b0010;
    tick();
    req = '0;
    wait_done(base + 1, "t4_done");
    check("t4_done_latency", 32'(done_cyc - c0), 32'(9));
    tick();

    // 6: fields scribbled on after grant must not matter
    set_client(0, 10, 20, 3, 2, 6);
    exp_gnt.push_back(0); push_rect(10, 20, 3, 2, 6); exp_done.push_back(0);
    base = done_cnt; c0 = cyc; req = 4'b0001;
    tick();
    set_client(0, 99, 99, 5, 5, 1);
    req = '0;
    wait_done(base + 1, "t6_done");
    check("t6_done_latency", 32'(done_cyc - c0), 32'(7));
    tick();

    // 5: reset midway through a 16x16 rectangle
    set_client(3, 0, 0, 16, 16, 7);
    exp_gnt.push_back(3); push_rect(0, 0, 16, 16, 7);
    c0 = cyc; req = 4'b1000;
    tick();
    req = '0;
    repeat (40) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_pix.delete();
    check("t5_plot_after_rst", 32'(plot), 32'(0));
    check("t5_busy_after_rst", 32'(busy), 32'(0));
    base = done_cnt;
    repeat (10) tick();
    check("t5_no_done", 32'(done_cnt), 32'(base));
    set_client(1, 5, 5, 1, 1, 2);
    set_client(3, 6, 6, 1, 1, 4);
    exp_gnt.push_back(1); push_pix(5, 5, 2); exp_done.push_back(1);
    exp_gnt.push_back(3); push_pix(6, 6, 4); exp_done.push_back(3);
    c0 = cyc; req = 4'b1010;
    tick();
    check("t5_first_gnt", 32'(gnt), 32'(4'b0010));
    wait_done(base + 2, "t5_done");
    req = '0;
    check("t5_second_done_cycle", 32'(done_cyc - c0), 32'(4));
    repeat (5) tick();

    check("end_pix_queue", 32'(exp_pix.size()), 32'(0));
    check("end_gnt_queue", 32'(exp_gnt.size()), 32'(0));
    check("end_done_queue", 32'(exp_done.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
